// File: rtl/dsp_ahb_interconnect_if.sv
// AHB-Lite bundle between the sync bridge, the DSP interconnect and its slave ports.
// The slave modport is the interconnect's view; master is the bridge/slave environment.
interface dsp_ahb_interconnect_if #(
    parameter int unsigned NSLV = 8,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
);
    logic                 hsel_s;
    logic [AW-1:0]        haddr_s;
    logic [1:0]           htrans_s;
    logic                 hready_s;
    logic                 hreadyout_s;
    logic                 hresp_s;
    logic [DW-1:0]        hrdata_s;
    logic [NSLV-1:0]      hsel_m;
    logic [NSLV-1:0]      hreadyout_m;
    logic [NSLV-1:0]      hresp_m;
    logic [NSLV*DW-1:0]   hrdata_m;

    modport slave (
        input  hsel_s, haddr_s, htrans_s, hready_s, hreadyout_m, hresp_m, hrdata_m,
        output hreadyout_s, hresp_s, hrdata_s, hsel_m
    );

    modport master (
        output hsel_s, haddr_s, htrans_s, hready_s, hreadyout_m, hresp_m, hrdata_m,
        input  hreadyout_s, hresp_s, hrdata_s, hsel_m
    );
endinterface

// File: rtl/dsp_ahb_interconnect.sv
// AHB-Lite decoder and slave mux with an error-responding default slave and a
// per-transfer wait-state watchdog that quarantines hung slaves until they recover.
module dsp_ahb_interconnect #(
    parameter int unsigned NSLV    = 8,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEC_MSB = 23,
    parameter int unsigned DEC_LSB = 16,
    parameter int unsigned BASE_ID = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    dsp_ahb_interconnect_if.slave bus,
    output logic [NSLV-1:0]      hung,
    output logic                 tout_pulse,
    output logic [AW-1:0]        tout_addr
);
    localparam int unsigned FW = DEC_MSB - DEC_LSB + 1;
    localparam int unsigned TW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSlv, StErr1, StErr2} state_e;

    state_e          state_q;
    logic [TW-1:0]   tgt_q;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   cnt_q;
    logic [NSLV-1:0] hung_q;
    logic [AW-1:0]   tout_addr_q;

    logic [FW-1:0]   field;
    logic [NSLV-1:0] hsel;
    logic [TW-1:0]   sel_idx;
    logic            accept;
    logic            tgt_rdy;
    logic            expire;
    logic            adv;
    state_e          ap_state;
    logic            unused_htrans0;

    assign field          = bus.haddr_s[DEC_MSB:DEC_LSB];
    assign unused_htrans0 = bus.htrans_s[0];

    // Decode uses the registered hung flags, so a same-cycle clear still misses.
    always_comb begin
        hsel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            hsel[i] = bus.hsel_s && (32'(field) == BASE_ID + i) && !hung_q[i];
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (hsel[i]) sel_idx = TW'(i);
        end
    end

    assign bus.hsel_m = hsel;
    assign accept     = bus.hsel_s && bus.hready_s && bus.htrans_s[1];
    assign ap_state   = accept ? ((|hsel) ? StSlv : StErr1) : StIdle;
    assign tgt_rdy    = bus.hreadyout_m[tgt_q];
    assign expire     = (state_q == StSlv) && !tgt_rdy && (TIMEOUT != 0) && (cnt_q == TMAX);
    assign adv        = bus.hready_s && (state_q != StErr1) && ((state_q != StSlv) || tgt_rdy);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= StIdle;
            tgt_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            hung_q      <= '0;
            tout_addr_q <= '0;
        end else begin
            hung_q <= hung_q & ~bus.hreadyout_m;
            if (state_q == StErr1) begin
                state_q <= StErr2;
            end else if (expire) begin
                // Expiry cycle itself presents ERR1, so the next cycle is ERR2.
                state_q        <= StErr2;
                hung_q[tgt_q]  <= 1'b1;
                tout_addr_q    <= addr_q;
            end else if (adv) begin
                state_q <= ap_state;
                if (accept) begin
                    tgt_q  <= sel_idx;
                    addr_q <= bus.haddr_s;
                    cnt_q  <= '0;
                end
            end else if ((state_q == StSlv) && !tgt_rdy && (cnt_q < TMAX)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        bus.hreadyout_s = 1'b1;
        bus.hresp_s     = 1'b0;
        bus.hrdata_s    = '0;
        tout_pulse      = 1'b0;
        case (state_q)
            StSlv: begin
                if (expire) begin
                    bus.hreadyout_s = 1'b0;
                    bus.hresp_s     = 1'b1;
                    tout_pulse      = 1'b1;
                end else begin
                    bus.hreadyout_s = tgt_rdy;
                    bus.hresp_s     = bus.hresp_m[tgt_q];
                    bus.hrdata_s    = bus.hrdata_m[tgt_q*DW +: DW];
                end
            end
            StErr1: begin
                bus.hreadyout_s = 1'b0;
                bus.hresp_s     = 1'b1;
            end
            StErr2: begin
                bus.hresp_s = 1'b1;
            end
            default: ;
        endcase
    end

    assign hung      = hung_q;
    assign tout_addr = tout_addr_q;
endmodule

// File: tb/tb_dsp_ahb_interconnect.sv
// Scoreboard bench for dsp_ahb_interconnect: directed transfers push expected data-phase
// results; a monitor pops them whenever a data phase completes.
module tb_dsp_ahb_interconnect;
    localparam int unsigned NSLV = 8;

    logic            hclk;
    logic            hresetn;
    logic [NSLV-1:0] hung;
    logic            tout_pulse;
    logic [31:0]     tout_addr;

    dsp_ahb_interconnect_if #(.NSLV(NSLV), .AW(32), .DW(32)) bus ();

    dsp_ahb_interconnect #(
        .NSLV(NSLV), .AW(32), .DW(32), .DEC_MSB(23), .DEC_LSB(16), .BASE_ID(1), .TIMEOUT(4)
    ) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .bus        (bus),
        .hung       (hung),
        .tout_pulse (tout_pulse),
        .tout_addr  (tout_addr)
    );

    assign bus.hready_s = bus.hreadyout_s;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Drive one NONSEQ address phase; cyc==0 means the data phase is not scored.
    task automatic issue(input logic [31:0] addr, input logic [31:0] rdata, input logic resp,
                         input int cyc, input logic [NSLV-1:0] exp_hsel);
        exp_t e;
        int   guard;
        bus.hsel_s   = 1'b1;
        bus.haddr_s  = addr;
        bus.htrans_s = 2'b10;
        if (cyc != 0) begin
            e.rdata = rdata;
            e.resp  = resp;
            e.cyc   = cyc;
            exp_q.push_back(e);
        end
        @(negedge hclk);
        chk($sformatf("hsel_m@%08h", addr), 64'(bus.hsel_m), 64'(exp_hsel));
        guard = 0;
        while (!bus.hready_s && guard < 50) begin
            @(negedge hclk);
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL addr_accept@%08h: hready stayed 0, expected 1", addr);
        end
        step();
        bus.hsel_s   = 1'b0;
        bus.htrans_s = 2'b00;
    endtask

    // Monitor: score each completed data phase against the queue head.
    initial begin
        bit   dp_active;
        int   dp_cyc;
        exp_t e;
        dp_active = 0;
        dp_cyc    = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                dp_active = 0;
                exp_q.delete();
            end else begin
                if (dp_active) begin
                    dp_cyc++;
                    if (bus.hreadyout_s) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_response: got resp %0b, expected none",
                                     bus.hresp_s);
                        end else begin
                            e = exp_q.pop_front();
                            chk("hrdata_s", 64'(bus.hrdata_s), 64'(e.rdata));
                            chk("hresp_s", 64'(bus.hresp_s), 64'(e.resp));
                            chk("dphase_cycles", 64'(dp_cyc), 64'(e.cyc));
                        end
                        dp_active = 0;
                    end else if (dp_cyc > 20) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dphase_bound: got %0d cycles, expected <= 20", dp_cyc);
                        dp_active = 0;
                    end
                end
                if (bus.hsel_s && bus.hready_s && bus.htrans_s[1]) begin
                    dp_active = 1;
                    dp_cyc    = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] pat;
        hresetn         = 1'b0;
        bus.hsel_s      = 1'b0;
        bus.haddr_s     = '0;
        bus.htrans_s    = 2'b00;
        bus.hreadyout_m = '1;
        bus.hresp_m     = '0;
        for (int i = 0; i < NSLV; i++) bus.hrdata_m[i*32 +: 32] = 32'hD000_0000 + 32'(i);

        @(negedge hclk);
        chk("rst_hreadyout_s", 64'(bus.hreadyout_s), 64'd1);
        chk("rst_hresp_s", 64'(bus.hresp_s), 64'd0);
        chk("rst_hrdata_s", 64'(bus.hrdata_s), 64'd0);
        chk("rst_hung", 64'(hung), 64'd0);
        chk("rst_tout", 64'({tout_pulse, tout_addr}), 64'd0);
        step();
        hresetn = 1'b1;
        step();

        // Slave 2, one wait state.
        bus.hrdata_m[2*32 +: 32] = 32'hA5A5_0001;
        issue(32'h0003_0010, 32'hA5A5_0001, 1'b0, 2, 8'h04);
        bus.hreadyout_m[2] = 1'b0;
        step();
        bus.hreadyout_m[2] = 1'b1;
        step();

        // Unmapped: two-cycle default-slave error.
        issue(32'h0000_0000, 32'h0, 1'b1, 2, 8'h00);
        @(negedge hclk);
        chk("err1_hreadyout_s", 64'(bus.hreadyout_s), 64'd0);
        chk("err1_hresp_s", 64'(bus.hresp_s), 64'd1);
        step();
        step();

        // Slave 3 ready on the cycle the counter reaches TIMEOUT: ready wins.
        bus.hreadyout_m[3] = 1'b0;
        issue(32'h0004_0000, 32'h3333_CAFE, 1'b0, 5, 8'h08);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk);
            pat[i] = tout_pulse;
            step();
            if (i == 3) begin
                bus.hreadyout_m[3]       = 1'b1;
                bus.hrdata_m[3*32 +: 32] = 32'h3333_CAFE;
            end
        end
        chk("ready_wins_no_pulse", 64'(pat), 64'd0);
        chk("ready_wins_hung", 64'(hung), 64'd0);

        // Slave 5 stalls: 4 waits, ERR1 (with pulse), ERR2.
        bus.hreadyout_m[5] = 1'b0;
        issue(32'h0006_0040, 32'h0, 1'b1, 6, 8'h20);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            pat[i] = tout_pulse;
        end
        chk("tout_pulse_pattern", 64'(pat), 64'b01_0000);
        chk("tout_addr", 64'(tout_addr), 64'h0006_0040);
        chk("hung_set", 64'(hung), 64'h20);
        step();

        // Quarantined slave 5 goes to the default slave until it shows ready.
        issue(32'h0006_0000, 32'h0, 1'b1, 2, 8'h00);
        bus.hreadyout_m[5] = 1'b1;
        step();
        @(negedge hclk);
        chk("hung_cleared", 64'(hung), 64'h00);
        step();
        issue(32'h0006_0000, 32'hD000_0005, 1'b0, 1, 8'h20);
        step();

        // Pipelined slave0 -> slave1 -> unmapped, reset during ERR1.
        issue(32'h0001_0000, 32'hD000_0000, 1'b0, 1, 8'h01);
        issue(32'h0002_0004, 32'hD000_0001, 1'b0, 1, 8'h02);
        issue(32'h00FF_0000, 32'h0, 1'b1, 0, 8'h00);
        hresetn = 1'b0;
        @(negedge hclk);
        chk("midrst_hreadyout_s", 64'(bus.hreadyout_s), 64'd1);
        chk("midrst_hresp_s", 64'(bus.hresp_s), 64'd0);
        chk("midrst_hung", 64'(hung), 64'd0);
        chk("midrst_tout_addr", 64'(tout_addr), 64'd0);
        step();
        hresetn = 1'b1;
        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
